int_div_sched: RTL and testbench

//  Schedules shared access to the L-lane pipelined integer divider (Int_Div) among R requesters.
//  - Round-robin arbitration, one issue per cycle.
//  - Drives the divider's clock enable and operands.
//  - Tracks in-flight tags, returns results with backpressure.
//  - Flags divide-by-zero lanes.

---
 rtl/int_div_pkg.sv | 26 ++
 rtl/int_div_sched_rr_arbiter.sv | 46 ++++
 rtl/int_div_sched.sv | 114 +++++++++++
 tb/tb_int_div_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_div_pkg.sv
// Shared constants and tag bundle for the Int_Div scheduler.
// Holds lane/requester geometry, divider latency and the tag-pipe entry type.
package int_div_pkg;

  localparam int N    = 32;
  localparam int L    = 4;
  localparam int R    = 4;
  localparam int LAT  = 6;
  localparam int ID_W = $clog2(R);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic [L-1:0]    dz;
  } div_tag_t;

  function automatic logic [L-1:0] zero_lanes(
    input logic [N*L-1:0] d
  );
    logic [L-1:0] z;
    for (int l = 0; l < L; l++)
      z[l] = (d[l*N +: N] == '0);
    return z;
  endfunction

endpackage

// File: rtl/int_div_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, wrapping modulo R.
// Ports: req, ptr, en in; grant_oh, grant_idx, ptr_next out.
module rr_arbiter #(
  parameter int R = 4,
  parameter int W = 2
) (
  input  logic [R-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [R-1:0] grant_oh,
  output logic [W-1:0] grant_idx,
  output logic [W-1:0] ptr_next
);

  logic         found;
  logic [W:0]   sum;
  logic [W-1:0] idx;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < R; i++) begin
      sum = {1'b0, ptr} + (W+1)'(i);
      if (sum >= (W+1)'(R))
        sum = sum - (W+1)'(R);
      idx = sum[W-1:0];
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    ptr_next = ptr;
    if (found && en) begin
      grant_oh[grant_idx] = 1'b1;
      ptr_next = (grant_idx == W'(R-1)) ? '0
                                        : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/int_div_sched.sv
// Shares one pipelined Int_Div among R requesters; tracks tags, flags /0 lanes.
// Ports: req_* in/ready out, div_* to/from divider, resp_* out with backpressure;
// INT_DIV_SCHED_PERF_EN adds perf_issued and perf_stall counters.
module int_div_sched
  import int_div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [R-1:0]        req_valid,
  output logic [R-1:0]        req_ready,
  input  logic [R*N*L-1:0]    req_denom,
  input  logic [R*N*L-1:0]    req_numer,
  output logic                div_clk_en,
  output logic [N*L-1:0]      div_denom,
  output logic [N*L-1:0]      div_numer,
  input  logic [N*L-1:0]      div_quotient,
  input  logic [N*L-1:0]      div_remainder,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ID_W-1:0]     resp_id,
  output logic [N*L-1:0]      resp_quotient,
  output logic [N*L-1:0]      resp_remainder,
  output logic [L-1:0]        resp_dz
`ifdef INT_DIV_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stall
`endif
);

  div_tag_t        tag [LAT];
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] grant_idx;
  logic [R-1:0]    grant_oh;
  logic            adv;
  logic            accept;
  logic [L-1:0]    dz_in;

  // Held in reset, nothing may issue and the divider stays frozen.
  assign adv        = !rst && (!resp_valid || resp_ready);
  assign div_clk_en = adv;
  assign req_ready  = grant_oh;
  assign accept     = |grant_oh;

  rr_arbiter #(
    .R (R),
    .W (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (adv),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .ptr_next  (ptr_next)
  );

  // One-hot mux; a bubble leaves the operands at zero.
  always_comb begin
    div_denom = '0;
    div_numer = '0;
    for (int r = 0; r < R; r++) begin
      if (grant_oh[r]) begin
        div_denom = req_denom[r*N*L +: N*L];
        div_numer = req_numer[r*N*L +: N*L];
      end
    end
  end

  assign dz_in = zero_lanes(div_denom) & {L{accept}};

  assign resp_valid = tag[LAT-1].v;
  assign resp_id    = tag[LAT-1].id;
  assign resp_dz    = tag[LAT-1].dz;

  always_comb begin
    for (int l = 0; l < L; l++) begin
      resp_quotient[l*N +: N] =
        resp_dz[l] ? '0 : div_quotient[l*N +: N];
      resp_remainder[l*N +: N] =
        resp_dz[l] ? '0 : div_remainder[l*N +: N];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++)
        tag[i] <= '0;
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
      if (adv) begin
        tag[0] <= '{v: accept, id: grant_idx, dz: dz_in};
        for (int i = 1; i < LAT; i++)
          tag[i] <= tag[i-1];
      end
    end
  end

`ifdef INT_DIV_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept)
        perf_issued <= perf_issued + 32'd1;
      if (!adv && resp_valid)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_int_div_sched.sv
// Self-checking bench for int_div_sched with a behavioural Int_Div model.
// Honours INT_DIV_SCHED_PERF_EN for the perf counter ports.
module tb_int_div_sched;
  import int_div_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [R-1:0]     req_valid;
  logic [R-1:0]     req_ready;
  logic [R*N*L-1:0] req_denom;
  logic [R*N*L-1:0] req_numer;
  logic             div_clk_en;
  logic [N*L-1:0]   div_denom;
  logic [N*L-1:0]   div_numer;
  logic [N*L-1:0]   div_quotient;
  logic [N*L-1:0]   div_remainder;
  logic             resp_valid;
  logic             resp_ready;
  logic [ID_W-1:0]  resp_id;
  logic [N*L-1:0]   resp_quotient;
  logic [N*L-1:0]   resp_remainder;
  logic [L-1:0]     resp_dz;
`ifdef INT_DIV_SCHED_PERF_EN
  logic [31:0]      perf_issued;
  logic [31:0]      perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  int_div_sched dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_denom      (req_denom),
    .req_numer      (req_numer),
    .div_clk_en     (div_clk_en),
    .div_denom      (div_denom),
    .div_numer      (div_numer),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_quotient  (resp_quotient),
    .resp_remainder (resp_remainder),
    .resp_dz        (resp_dz)
`ifdef INT_DIV_SCHED_PERF_EN
    ,
    .perf_issued    (perf_issued),
    .perf_stall     (perf_stall)
`endif
  );

  task automatic chk(input string nm,
                     input logic [N*L-1:0] act,
                     input logic [N*L-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Int_Div stand-in: LAT enabled stages, garbage on /0 lanes.
  logic [N*L-1:0] dq [LAT];
  logic [N*L-1:0] dr [LAT];

  always @(posedge clk) begin
    if (div_clk_en) begin
      for (int i = LAT-1; i > 0; i--) begin
        dq[i] <= dq[i-1];
        dr[i] <= dr[i-1];
      end
      for (int l = 0; l < L; l++) begin
        if (div_denom[l*N +: N] == '0) begin
          dq[0][l*N +: N] <= '1;
          dr[0][l*N +: N] <= '1;
        end else begin
          dq[0][l*N +: N] <= div_numer[l*N +: N] / div_denom[l*N +: N];
          dr[0][l*N +: N] <= div_numer[l*N +: N] % div_denom[l*N +: N];
        end
      end
    end
  end

  assign div_quotient  = dq[LAT-1];
  assign div_remainder = dr[LAT-1];

  // Reference model: ordered list of in-flight ops, each needing
  // LAT-1 further advancing edges after its accept edge to appear.
  typedef struct {
    int             id;
    logic [N*L-1:0] q;
    logic [N*L-1:0] r;
    logic [L-1:0]   dz;
    int             left;
  } op_t;

  op_t         mq[$];
  int          mptr = 0;
  int          g;
  bit          exp_v;
  bit          madv;
  op_t         nop;
  logic [R-1:0] exp_rdy;
  logic [31:0] m_issued = 0;
  logic [31:0] m_stall  = 0;
  logic [N-1:0] ln, ld;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      mptr = 0;
      m_issued = 0;
      m_stall  = 0;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_clk_en", div_clk_en, 0);
    end else begin
      exp_v = (mq.size() > 0) && (mq[0].left == 0);
      chk("resp_valid", resp_valid, exp_v);
      if (exp_v) begin
        chk("resp_id", resp_id, mq[0].id);
        chk("resp_quotient", resp_quotient, mq[0].q);
        chk("resp_remainder", resp_remainder, mq[0].r);
        chk("resp_dz", resp_dz, mq[0].dz);
      end
      madv = !exp_v || resp_ready;
      chk("div_clk_en", div_clk_en, madv);
      g = -1;
      for (int k = 0; k < R; k++)
        if (g < 0 && req_valid[(mptr + k) % R])
          g = (mptr + k) % R;
      exp_rdy = '0;
      if (madv && g >= 0)
        exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
`ifdef INT_DIV_SCHED_PERF_EN
      chk("perf_issued", perf_issued, m_issued);
      chk("perf_stall", perf_stall, m_stall);
      if (!madv && exp_v)
        m_stall = m_stall + 1;
`endif
      if (madv) begin
        if (exp_v)
          void'(mq.pop_front());
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].left > 0)
            mq[i].left = mq[i].left - 1;
        if (g >= 0) begin
          nop.id = g;
          nop.left = LAT - 1;
          for (int l = 0; l < L; l++) begin
            ln = req_numer[g*N*L + l*N +: N];
            ld = req_denom[g*N*L + l*N +: N];
            nop.dz[l] = (ld == 0);
            nop.q[l*N +: N] = (ld == 0) ? '0 : ln / ld;
            nop.r[l*N +: N] = (ld == 0) ? '0 : ln % ld;
          end
          mq.push_back(nop);
          mptr = (g + 1) % R;
          m_issued = m_issued + 1;
        end
      end
    end
  end

  task automatic set_all(input int r, input int n, input int d);
    for (int l = 0; l < L; l++) begin
      req_numer[r*N*L + l*N +: N] = N'(n);
      req_denom[r*N*L + l*N +: N] = N'(d);
    end
  endtask

  task automatic set_mix(input int r);
    for (int l = 0; l < L; l++) begin
      req_numer[r*N*L + l*N +: N] = N'(1000 + 37*r + 11*l);
      req_denom[r*N*L + l*N +: N] = N'(r + l + 2);
    end
  endtask

  task automatic wait_resp(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, resp_valid, 1);
  endtask

  logic [N*L-1:0] held;
  int drained;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_denom = '0;
    req_numer = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t0_resp_id", resp_id, 0);
    chk("t0_resp_dz", resp_dz, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // single op 100/7 from requester 0
    set_all(0, 100, 7);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t1_early", resp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_valid", resp_valid, 1);
    chk("t1_quot", resp_quotient, {4{32'd14}});
    chk("t1_rem", resp_remainder, {4{32'd2}});
    chk("t1_id", resp_id, 0);
    chk("t1_dz", resp_dz, 0);

    // all four requesters, round robin from ptr 0
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int r = 0; r < R; r++)
      set_mix(r);
    req_valid = 4'hf;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t2_grant", req_ready, 4'b0001 << (i % 4));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    repeat (LAT + 2) @(posedge clk);
    #1;

    // lane 2 divides by zero
    set_all(0, 9, 3);
    req_denom[0*N*L + 2*N +: N] = '0;
    req_valid = 4'b0001;
    @(posedge clk);
    #1 req_valid = '0;
    wait_resp("t3_wait");
    chk("t3_dz", resp_dz, 4'b0100);
    chk("t3_q2", resp_quotient[2*N +: N], 0);
    chk("t3_r2", resp_remainder[2*N +: N], 0);
    chk("t3_q0", resp_quotient[0 +: N], 3);
    chk("t3_q3", resp_quotient[3*N +: N], 3);
    @(posedge clk);
    #1;

    // fill the pipe under backpressure, hold, then drain
    resp_ready = 1'b0;
    for (int r = 0; r < R; r++)
      set_mix(r);
    set_all(3, 55, 0);
    req_valid = 4'hf;
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    held = resp_quotient;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_ready", req_ready, 0);
      chk("t4_clk_en", div_clk_en, 0);
      chk("t4_hold", resp_quotient, held);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    req_valid = '0;
    drained = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        drained++;
        if (resp_id == 2'd3)
          chk("t4_all_dz", resp_dz, 4'hf);
      end
    end
    chk("t4_drained", drained, LAT);

    // reset with three ops in flight
    @(posedge clk);
    #1 req_valid = 4'b0111;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    wait_resp("t5_wait");
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("t5_drop", resp_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t5_stale", resp_valid, 0);
    end

`ifdef INT_DIV_SCHED_PERF_EN
    // five accepts, three stall cycles
    @(posedge clk);
    #1 resp_ready = 1'b0;
    set_all(0, 40, 5);
    req_valid = 4'b0001;
    repeat (5) @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 resp_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t6_issued", perf_issued, 5);
    chk("t6_stall", perf_stall, 3);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
